// File: rtl/led_pattern_if.sv
// LED pattern generator control/status bundle: pattern select and run enable in,
// LED drive and step strobe out.
interface led_pattern_if #(
   parameter int NLED = 8
);
   logic [1:0]      mode;
   logic            en;
   logic [NLED-1:0] prled;
   logic            step;

   modport master (output mode, output en, input prled, input step);
   modport slave  (input mode, input en, output prled, output step);
endinterface

// File: rtl/led_pattern.sv
// Parametrised LED pattern generator: alternate, chase, bounce and PWM breathe patterns
// stepped by clock prescalers, with registered LED outputs and a one-cycle step strobe.
module led_pattern #(
   parameter int CLK_HZ    = 10000000,
   parameter int STEP_HZ   = 2,
   parameter int BREATH_HZ = 512,
   parameter int NLED      = 8,
   parameter int PWM_BITS  = 8
) (
   input  logic         clk,
   input  logic         rst,
   led_pattern_if.slave bus
);

   localparam int DIV    = CLK_HZ / STEP_HZ;
   localparam int BDIV   = CLK_HZ / BREATH_HZ;
   localparam int SCNT_W = $clog2(DIV);
   localparam int BCNT_W = $clog2(BDIV);
   localparam int POS_W  = $clog2(NLED);

   localparam logic [SCNT_W-1:0]   SCNT_MAX = SCNT_W'(DIV - 1);
   localparam logic [SCNT_W-1:0]   SCNT_ONE = SCNT_W'(1);
   localparam logic [BCNT_W-1:0]   BCNT_MAX = BCNT_W'(BDIV - 1);
   localparam logic [BCNT_W-1:0]   BCNT_ONE = BCNT_W'(1);
   localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NLED - 1);
   localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
   localparam logic [NLED-1:0]     LED_ONE  = NLED'(1);

   typedef enum logic [1:0] {
      M_ALT     = 2'd0,
      M_CHASE   = 2'd1,
      M_BOUNCE  = 2'd2,
      M_BREATHE = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   function automatic logic [NLED-1:0] f_even_mask();
      logic [NLED-1:0] m;
      for (int i = 0; i < NLED; i++) begin
         m[i] = ((i % 2) == 0);
      end
      return m;
   endfunction

   localparam logic [NLED-1:0] EVEN_MASK = f_even_mask();

   // Duty is at an end of its ramp when it cannot move further in the current direction
   function automatic logic f_duty_sat(input logic [PWM_BITS-1:0] duty, input dir_e bdir);
      return (bdir == DIR_UP) ? (duty == DUTY_MAX) : (duty == '0);
   endfunction

   function automatic logic [PWM_BITS-1:0] f_duty_next(input logic [PWM_BITS-1:0] duty,
                                                       input dir_e bdir);
      logic up;
      up = (bdir == DIR_UP) ^ f_duty_sat(duty, bdir);
      return up ? (duty + DUTY_ONE) : (duty - DUTY_ONE);
   endfunction

   mode_e               r_mode_q;
   logic                r_alt_phase;
   logic [POS_W-1:0]    r_pos;
   dir_e                r_dir;
   logic [PWM_BITS-1:0] r_duty;
   dir_e                r_bdir;
   logic [SCNT_W-1:0]   r_scnt;
   logic [BCNT_W-1:0]   r_bcnt;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                r_tick;
   logic [NLED-1:0]     r_prled;
   logic                r_step;

   logic                w_mode_chg;
   logic                w_run;
   logic                w_step_tick;
   logic                w_breath_tick;
   logic                w_pulse;
   logic                w_alt_phase_nxt;
   logic [POS_W-1:0]    w_pos_nxt;
   dir_e                w_dir_nxt;
   logic [PWM_BITS-1:0] w_duty_nxt;
   dir_e                w_bdir_nxt;
   logic [SCNT_W-1:0]   w_scnt_nxt;
   logic [BCNT_W-1:0]   w_bcnt_nxt;
   logic [NLED-1:0]     w_pat;

   // A mode change suppresses all ticks and returns pattern state to reset values
   always_comb begin
      w_mode_chg    = (bus.mode != r_mode_q);
      w_run         = bus.en & ~w_mode_chg;
      w_step_tick   = w_run & (r_scnt == SCNT_MAX);
      w_breath_tick = w_run & (r_mode_q == M_BREATHE) & (r_bcnt == BCNT_MAX);
      w_pulse       = (w_step_tick & (r_mode_q != M_BREATHE)) |
                      (w_breath_tick & (r_bdir == DIR_DN) & (r_duty == DUTY_ONE));

      w_alt_phase_nxt = r_alt_phase;
      w_pos_nxt       = r_pos;
      w_dir_nxt       = r_dir;
      w_duty_nxt      = r_duty;
      w_bdir_nxt      = r_bdir;
      w_scnt_nxt      = r_scnt;
      w_bcnt_nxt      = r_bcnt;

      if (w_mode_chg) begin
         w_alt_phase_nxt = 1'b1;
         w_pos_nxt       = '0;
         w_dir_nxt       = DIR_UP;
         w_duty_nxt      = '0;
         w_bdir_nxt      = DIR_UP;
         w_scnt_nxt      = '0;
         w_bcnt_nxt      = '0;
      end else if (bus.en) begin
         w_scnt_nxt = w_step_tick ? '0 : (r_scnt + SCNT_ONE);
         if (r_mode_q == M_BREATHE) begin
            w_bcnt_nxt = w_breath_tick ? '0 : (r_bcnt + BCNT_ONE);
         end
         if (w_step_tick) begin
            case (r_mode_q)
               M_ALT:   w_alt_phase_nxt = ~r_alt_phase;
               M_CHASE: w_pos_nxt = (r_pos == POS_LAST) ? '0 : (r_pos + POS_ONE);
               M_BOUNCE: begin
                  // Reverse and move off the end in one step so end positions never repeat
                  if (r_dir == DIR_UP) begin
                     if (r_pos == POS_LAST) begin
                        w_dir_nxt = DIR_DN;
                        w_pos_nxt = r_pos - POS_ONE;
                     end else begin
                        w_pos_nxt = r_pos + POS_ONE;
                     end
                  end else begin
                     if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                        w_pos_nxt = r_pos + POS_ONE;
                     end else begin
                        w_pos_nxt = r_pos - POS_ONE;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (w_breath_tick) begin
            w_duty_nxt = f_duty_next(r_duty, r_bdir);
            if (f_duty_sat(r_duty, r_bdir)) begin
               w_bdir_nxt = (r_bdir == DIR_UP) ? DIR_DN : DIR_UP;
            end
         end
      end
   end

   always_comb begin
      w_pat = EVEN_MASK;
      case (r_mode_q)
         M_ALT:             w_pat = r_alt_phase ? EVEN_MASK : ~EVEN_MASK;
         M_CHASE, M_BOUNCE: w_pat = LED_ONE << r_pos;
         M_BREATHE:         w_pat = {NLED{r_pwm_cnt < r_duty}};
         default:           w_pat = EVEN_MASK;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode_q    <= M_ALT;
         r_alt_phase <= 1'b1;
         r_pos       <= '0;
         r_dir       <= DIR_UP;
         r_duty      <= '0;
         r_bdir      <= DIR_UP;
         r_scnt      <= '0;
         r_bcnt      <= '0;
         r_pwm_cnt   <= '0;
         r_tick      <= 1'b0;
         r_prled     <= EVEN_MASK;
         r_step      <= 1'b0;
      end else begin
         r_mode_q    <= mode_e'(bus.mode);
         r_alt_phase <= w_alt_phase_nxt;
         r_pos       <= w_pos_nxt;
         r_dir       <= w_dir_nxt;
         r_duty      <= w_duty_nxt;
         r_bdir      <= w_bdir_nxt;
         r_scnt      <= w_scnt_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_pwm_cnt   <= r_pwm_cnt + DUTY_ONE;
         // Output stage: LEDs and strobe show the state committed on the previous edge
         r_tick      <= w_pulse;
         r_prled     <= w_pat;
         r_step      <= r_tick;
      end
   end

   assign bus.prled = r_prled;
   assign bus.step  = r_step;

endmodule

// File: tb/tb_led_pattern.sv
// Self-checking bench for led_pattern: directed pattern/boundary scenarios plus random
// mode/enable traffic compared against a tick-count based reference model.
module tb_led_pattern;

   localparam int DIV      = 10;
   localparam int BDIV     = 2;
   localparam int NLED     = 8;
   localparam int PWM_BITS = 4;
   localparam int PMAX     = 1 << PWM_BITS;
   localparam int BPER     = 2 * PMAX - 2;
   localparam int KPER     = 2 * NLED - 2;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   // Reference model: ticks counted since the last mode change, not LED state
   int              m_mode_q, m_sc, m_bc, m_k, m_b, m_pwm;
   bit              m_pend;
   logic [NLED-1:0] exp_prled;
   logic            exp_step;

   led_pattern_if #(.NLED(NLED)) bus ();

   led_pattern #(
      .CLK_HZ   (100),
      .STEP_HZ  (10),
      .BREATH_HZ(50),
      .NLED     (NLED),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int duty_of(input int b);
      int q;
      q = b % BPER;
      return (q < PMAX) ? q : (BPER - q);
   endfunction

   function automatic logic [NLED-1:0] pattern(input int md, input int k, input int b, input int pwm);
      int p;
      case (md)
         0: return ((k % 2) == 0) ? 8'h55 : 8'hAA;
         1: return 8'h01 << (k % NLED);
         2: begin
            p = k % KPER;
            return 8'h01 << ((p < NLED) ? p : (KPER - p));
         end
         default: return (pwm < duty_of(b)) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_mode_q = 0; m_sc = 0; m_bc = 0; m_k = 0; m_b = 0; m_pwm = 0;
      m_pend = 0; exp_prled = 8'h55; exp_step = 1'b0;
   endtask

   task automatic model_update();
      logic [NLED-1:0] np;
      bit ns, pulse;
      int md;
      md    = int'(bus.mode);
      np    = pattern(m_mode_q, m_k, m_b, m_pwm);
      ns    = m_pend;
      pulse = 0;
      if (md != m_mode_q) begin
         m_sc = 0; m_bc = 0; m_k = 0; m_b = 0;
      end else if (bus.en) begin
         if (m_sc == DIV - 1) begin
            m_sc = 0; m_k++;
            if (m_mode_q != 3) pulse = 1;
         end else m_sc++;
         if (m_mode_q == 3) begin
            if (m_bc == BDIV - 1) begin
               m_bc = 0; m_b++;
               if ((m_b % BPER) == 0) pulse = 1;
            end else m_bc++;
         end
      end
      m_pend = pulse; m_mode_q = md; m_pwm = (m_pwm + 1) % PMAX;
      exp_prled = np; exp_step = ns;
   endtask

   // Inputs change at negedge, model advances with the posedge, outputs sampled at negedge
   task automatic cycle();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_step(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         cycle();
         n++;
         if (bus.step === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      logic es;
      rst = 1'b0; bus.mode = 2'd0; bus.en = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.prled !== 8'h55) begin errors++; $display("FAIL reset_prled: got %h expected 55", bus.prled); end
         checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", bus.step); end
      end
      rst = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         cycle();
         es = (i == 11);
         checks++; if (bus.step !== es) begin errors++; $display("FAIL first_step cyc %0d: got %b expected %b", i, bus.step, es); end
      end
      checks++; if (bus.prled !== 8'hAA) begin errors++; $display("FAIL first_step_prled: got %h expected aa", bus.prled); end
      for (int i = 1; i <= 10; i++) begin
         cycle();
         es = (i == 10);
         checks++; if (bus.step !== es) begin errors++; $display("FAIL second_step cyc %0d: got %b expected %b", i, bus.step, es); end
      end
      checks++; if (bus.prled !== 8'h55) begin errors++; $display("FAIL second_step_prled: got %h expected 55", bus.prled); end
   endtask

   task automatic test_chase();
      int n;
      logic [NLED-1:0] e;
      bus.mode = 2'd1;
      cycle(); cycle();
      checks++; if (bus.prled !== 8'h01) begin errors++; $display("FAIL chase_start: got %h expected 01", bus.prled); end
      for (int i = 1; i <= 9; i++) begin
         wait_step(20, n);
         e = 8'h01 << (i % NLED);
         checks++; if (n != DIV) begin errors++; $display("FAIL chase_gap %0d: got %0d expected %0d", i, n, DIV); end
         checks++; if (bus.prled !== e) begin errors++; $display("FAIL chase_prled %0d: got %h expected %h", i, bus.prled, e); end
      end
   endtask

   task automatic test_bounce();
      int n;
      logic [NLED-1:0] seq [16];
      seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      bus.mode = 2'd2;
      cycle(); cycle();
      checks++; if (bus.prled !== seq[0]) begin errors++; $display("FAIL bounce_start: got %h expected %h", bus.prled, seq[0]); end
      for (int i = 1; i < 16; i++) begin
         wait_step(20, n);
         checks++; if (n != DIV) begin errors++; $display("FAIL bounce_gap %0d: got %0d expected %0d", i, n, DIV); end
         checks++; if (bus.prled !== seq[i]) begin errors++; $display("FAIL bounce_prled %0d: got %h expected %h", i, bus.prled, seq[i]); end
      end
   endtask

   task automatic test_breathe();
      int n, on, bad;
      logic es;
      bus.mode = 2'd3;
      cycle(); cycle();
      wait_step(100, n);
      checks++; if (n != BPER * BDIV) begin errors++; $display("FAIL breathe_first_period: got %0d expected %0d", n, BPER * BDIV); end
      for (int c = 1; c <= BPER * BDIV; c++) begin
         cycle();
         es = (c == BPER * BDIV);
         checks++; if (bus.step !== es) begin errors++; $display("FAIL breathe_step cyc %0d: got %b expected %b", c, bus.step, es); end
         checks++; if (bus.prled !== exp_prled) begin errors++; $display("FAIL breathe_prled cyc %0d: got %h expected %h", c, bus.prled, exp_prled); end
      end
      n = 0;
      while (duty_of(m_b) != 8 && n < 100) begin cycle(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL breathe_reach_duty8: got timeout expected duty 8"); end
      bus.en = 1'b0;
      cycle(); cycle();
      on = 0; bad = 0;
      for (int c = 0; c < PMAX; c++) begin
         cycle();
         if (bus.prled === 8'hFF) on++;
         else if (bus.prled !== 8'h00) bad++;
         if (bus.step !== 1'b0) bad++;
      end
      checks++; if (on != 8) begin errors++; $display("FAIL breathe_duty8_on: got %0d expected 8", on); end
      checks++; if (bad != 0) begin errors++; $display("FAIL breathe_duty8_shape: got %0d bad cycles expected 0", bad); end
      bus.en = 1'b1;
   endtask

   task automatic test_en_hold();
      int n;
      logic es;
      bus.mode = 2'd1;
      cycle(); cycle();
      for (int i = 1; i <= 3; i++) begin
         wait_step(20, n);
         checks++; if (n != DIV) begin errors++; $display("FAIL en_pre_gap %0d: got %0d expected %0d", i, n, DIV); end
      end
      checks++; if (bus.prled !== 8'h08) begin errors++; $display("FAIL en_pos3: got %h expected 08", bus.prled); end
      cycle(); cycle(); cycle();
      bus.en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cycle();
         checks++; if (bus.prled !== 8'h08) begin errors++; $display("FAIL en_hold_prled cyc %0d: got %h expected 08", i, bus.prled); end
         checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL en_hold_step cyc %0d: got %b expected 0", i, bus.step); end
      end
      bus.en = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         cycle();
         es = (i == 7);
         checks++; if (bus.step !== es) begin errors++; $display("FAIL en_resume_step cyc %0d: got %b expected %b", i, bus.step, es); end
      end
      checks++; if (bus.prled !== 8'h10) begin errors++; $display("FAIL en_resume_prled: got %h expected 10", bus.prled); end
   endtask

   task automatic test_mode_change();
      int n;
      bus.mode = 2'd0;
      cycle(); cycle();
      checks++; if (bus.prled !== 8'h55) begin errors++; $display("FAIL mode_1to0: got %h expected 55", bus.prled); end
      bus.mode = 2'd1; bus.en = 1'b0;
      cycle(); cycle(); cycle();
      checks++; if (bus.prled !== 8'h01) begin errors++; $display("FAIL mode_en_same: got %h expected 01", bus.prled); end
      for (int i = 0; i < 20; i++) begin
         cycle();
         checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL mode_en_frozen_step cyc %0d: got %b expected 0", i, bus.step); end
      end
      checks++; if (bus.prled !== 8'h01) begin errors++; $display("FAIL mode_en_frozen_prled: got %h expected 01", bus.prled); end
      bus.en = 1'b1;
      wait_step(20, n);
      checks++; if (n != DIV + 1) begin errors++; $display("FAIL mode_en_first_gap: got %0d expected %0d", n, DIV + 1); end
      checks++; if (bus.prled !== 8'h02) begin errors++; $display("FAIL mode_en_first_prled: got %h expected 02", bus.prled); end
   endtask

   task automatic test_async_reset();
      int n;
      logic es;
      bus.mode = 2'd2;
      cycle(); cycle();
      for (int i = 0; i < 5; i++) wait_step(20, n);
      checks++; if (bus.prled !== 8'h20) begin errors++; $display("FAIL async_pre_pos5: got %h expected 20", bus.prled); end
      #2;
      rst = 1'b0; bus.mode = 2'd0;
      #1;
      checks++; if (bus.prled !== 8'h55) begin errors++; $display("FAIL async_prled: got %h expected 55", bus.prled); end
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL async_step: got %b expected 0", bus.step); end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         cycle();
         es = (i == 11);
         checks++; if (bus.step !== es) begin errors++; $display("FAIL async_restart_step cyc %0d: got %b expected %b", i, bus.step, es); end
      end
      checks++; if (bus.prled !== 8'hAA) begin errors++; $display("FAIL async_restart_prled: got %h expected aa", bus.prled); end
   endtask

   task automatic test_random();
      bus.en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
         cycle();
         checks++; if (bus.prled !== exp_prled) begin errors++; $display("FAIL random_prled cyc %0d: got %h expected %h", i, bus.prled, exp_prled); end
         checks++; if (bus.step !== exp_step) begin errors++; $display("FAIL random_step cyc %0d: got %b expected %b", i, bus.step, exp_step); end
      end
   endtask

   initial begin
      test_reset();
      test_chase();
      test_bounce();
      test_breathe();
      test_en_hold();
      test_mode_change();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_pattern.md
# led_pattern

Parametrised LED pattern generator driving the prototype board's LED bank from the system clock. It generalises the fixed 2 Hz alternate blinker: the LED count and step rate are configurable, and there are four run-time selectable patterns (alternate, chase, bounce, PWM breathe). The block sits directly between the board clock/reset pins and the `prled` outputs, and exports a step strobe that other demo logic can use for synchronisation.

## Interface
- `CLK_HZ`, 10000000, system clock frequency in Hz.
- `STEP_HZ`, 2, pattern steps per second; `DIV = CLK_HZ/STEP_HZ` must be an integer ≥ 2.
- `BREATH_HZ`, 512, duty updates per second in breathe mode; `BDIV = CLK_HZ/BREATH_HZ` must be an integer ≥ 2.
- `NLED`, 8, number of LEDs, ≥ 2.
- `PWM_BITS`, 8, width of the PWM counter and the duty register.
- `clk  input  1  system clock; all logic on posedge`
- `rst  input  1  asynchronous, active-low reset`
- `mode  input  2  pattern select: 0 alternate, 1 chase, 2 bounce, 3 breathe`
- `en  input  1  run enable; low freezes pattern and prescalers`
- `prled  output  NLED  LED drive, registered, active-high`
- `step  output  1  one-cycle strobe on each pattern step, registered`

## Operation
- One clock domain, and one reset. Reset is asynchronous and active-low: `rst` low immediately clears all state.
- Reset state:
  - `mode_q` = 0, `alt_phase` = 1, `pos` = 0, `dir` = up.
  - `duty` = 0, `bdir` = up, both prescalers = 0, `pwm_cnt` = 0.
  - Outputs: `prled` = even bits set (8'h55 for `NLED` = 8), `step` = 0.
- Step prescaler `scnt`, width `$clog2(DIV)`:
  - Counts 0..DIV-1 while `en` = 1; the step tick is `scnt == DIV-1`, after which it wraps to 0.
  - Holds its value while `en` = 0.
- Breath prescaler `bcnt` behaves the same way with `BDIV`, and only runs in mode 3.
- `pwm_cnt` is `PWM_BITS` wide and free-running. It wraps naturally and ignores `en`.
- `mode` is registered into `mode_q` every cycle. When `mode` != `mode_q`:
  - Pattern state and both prescalers return to their reset values.
  - No tick fires in that cycle.
  - The new pattern is visible on the following cycle.
- Patterns, each advancing on a step tick:
  - **Alternate:** `alt_phase` toggles. Even-indexed LEDs = `alt_phase`, odd-indexed LEDs = ~`alt_phase`.
  - **Chase:** one-hot at `pos`. `pos` increments and wraps from NLED-1 to 0.
  - **Bounce:** one-hot at `pos`, sequence 0,1,…,NLED-1,NLED-2,…,1,0,1…, period 2·NLED-2 steps. At an end, `dir` flips and `pos` moves away from the end in the same tick, so the end value never repeats.
  - **Breathe:** all LEDs = (`pwm_cnt` < `duty`).
    - `duty` steps ±1 on each breath tick, ramping 0→2^PWM_BITS-1→0 with no repeated endpoint.
    - `step` pulses when `duty` returns to 0.
    - `duty` = 0 gives fully off; maximum duty gives 255/256 on.
- `en` = 0:
  - Pattern state, prescalers and `duty` hold, and `step` stays 0.
  - `prled` holds the current pattern. In breathe mode PWM continues at the held duty.
- Mode change and `en` fall in the same cycle: the mode reset wins, and the state then stays frozen at its reset values.

## Timing
- A tick at clock edge N updates the pattern state at edge N. `prled` and `step` reflect it after edge N+1, a fixed 1-cycle output register latency.
- `step` is high for exactly one cycle per step, coincident with the `prled` update.
- With `en` held high, consecutive `step` pulses are exactly DIV cycles apart.
- After `rst` deasserts, the first tick comes DIV cycles later. `rst` asserted mid-pattern forces the reset values asynchronously, with no glitch to an intermediate pattern.
- Breathe mode: output updates lag `pwm_cnt` by 1 cycle. A full breath period is (2·(2^PWM_BITS)-2)·BDIV cycles.
- Arithmetic:
  - `pos` is `$clog2(NLED)` wide and compared explicitly against NLED-1, never relying on natural wrap.
  - `duty` saturation is detected by comparison against all-ones / zero before the increment or decrement.

## Test plan
Parameters for all scenarios: CLK_HZ=100, STEP_HZ=10 (DIV=10), BREATH_HZ=50 (BDIV=2), NLED=8, PWM_BITS=4.

1. **Reset, mode 0, en = 1:** `prled` = 8'h55 during reset. The first `step` comes 11 cycles after release, with `prled` = 8'hAA. The next step comes 10 cycles later with `prled` = 8'h55.
2. **Chase, mode 1:** `prled` sequence is 01,02,04,…,80,01 across 9 consecutive `step` pulses.
3. **Bounce, mode 2:** 16 steps give 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. No repeated 80 or 01.
4. **Breathe, mode 3:**
   - `duty` ramps 0→15→0 over 30 updates (60 cycles).
   - At `duty` = 8, `prled` = 8'hFF for 8 of every 16 cycles.
   - `step` pulses once per breath period.
5. **en and mode-change boundaries:**
   - `en` low for 50 cycles mid-chase at `pos` = 3: `prled` stays 8'h08 and no `step` fires. After re-enable, the next step arrives after the remaining count.
   - Mode 1→0 change: `prled` = 8'h55 within 2 cycles.
6. **Async reset mid-bounce at `pos` = 5:** `prled` = 8'h55 immediately, without waiting for a clock edge. After release, the sequence restarts at mode 0 timing.
